controlador_ula: RTL and testbench

- Command-issue stage directly upstream of the 8-bit ALU.
- Accepts (a, b, opcode) commands over a valid/ready interface into a small FIFO.
- Drives the ALU operand and opcode inputs and holds them stable for the ALU's registered latency.
- Captures the ALU result and flag, and presents them downstream over a valid/ready interface.

---
 rtl/ula_pkg.sv | 31 +++
 rtl/fifo_comandos.sv | 54 +++++
 rtl/controlador_ula.sv | 164 ++++++++++++++++
 tb/tb_controlador_ula.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ALU command-issue stage.
//   - ULA_N      : operand/result width of the attached ALU.
//   - OP_*       : ALU opcode encodings.
//   - estado_t   : issue FSM states.
//   - comando_t  : one queued command {a, b, op}; this is the FIFO word layout.
package ula_pkg;

    localparam int ULA_N = 8;

    localparam logic [2:0] OP_SOMA  = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOT   = 3'b101;
    localparam logic [2:0] OP_IGUAL = 3'b110;
    localparam logic [2:0] OP_DIF   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } estado_t;

    typedef struct packed {
        logic [ULA_N-1:0] a;
        logic [ULA_N-1:0] b;
        logic [2:0]       op;
    } comando_t;

endpackage

// File: rtl/fifo_comandos.sv
// fifo_comandos: DEPTH x W synchronous FIFO holding pending ALU commands.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   push, din    : write request and data (ignored while full)
//   pop, dout    : read request (ignored while empty); dout shows the head word
//   full, empty  : occupancy flags
// Push and pop in the same cycle are both honoured. There is no bypass:
// a word written into an empty FIFO appears on dout on the following cycle.
module fifo_comandos #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits are equal.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/controlador_ula.sv
// controlador_ula: command-issue stage in front of the registered 8-bit ALU.
// Ports:
//   clk, rst_n                 : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        : command handshake; cmd_a, cmd_b, cmd_op payload
//   alu_a, alu_b, alu_opcode   : operands/opcode driven to the ALU
//   alu_s, alu_flag            : ALU result and carry/borrow flag
//   res_valid/res_ready        : result handshake; res_s, res_flag, res_op payload
//   busy                       : FSM is not in IDLE
//   op_count [15:0]            : result handshake counter, present only when
//                                CONTROLADOR_ULA_CONTADOR_EN is defined
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender keeps valid and payload stable until then, and res_* stays stable
// for as long as res_valid is high.
// N must equal ula_pkg::ULA_N, since the FIFO word is a comando_t.
module controlador_ula
    import ula_pkg::*;
#(
    parameter int N       = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic [2:0]   cmd_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    input  logic [N-1:0] alu_s,
    input  logic         alu_flag,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_s,
    output logic         res_flag,
    output logic [2:0]   res_op,
    output logic         busy
`ifdef CONTROLADOR_ULA_CONTADOR_EN
    ,
    output logic [15:0]  op_count
`endif
);
    localparam int CW = $clog2(ALU_LAT + 1);

    estado_t  state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    comando_t cmd_in;
    comando_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     push;
    logic     pop;

    logic [N-1:0] alu_a_n, alu_b_n, res_s_n;
    logic [2:0]   alu_opcode_n, res_op_n;
    logic         res_flag_n, res_valid_n;

    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = (state != IDLE);

    fifo_comandos #(
        .W     ($bits(comando_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (cmd_in),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_s      <= '0;
            res_flag   <= 1'b0;
            res_op     <= '0;
            res_valid  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            alu_a      <= alu_a_n;
            alu_b      <= alu_b_n;
            alu_opcode <= alu_opcode_n;
            res_s      <= res_s_n;
            res_flag   <= res_flag_n;
            res_op     <= res_op_n;
            res_valid  <= res_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        alu_a_n      = alu_a;
        alu_b_n      = alu_b;
        alu_opcode_n = alu_opcode;
        res_s_n      = res_s;
        res_flag_n   = res_flag;
        res_op_n     = res_op;
        res_valid_n  = res_valid;

        case (state)
            IDLE: begin
                // The ALU operands only ever change here, so the ALU sees
                // one stable operand set for the whole WAIT window.
                if (!fifo_empty) begin
                    alu_a_n      = head.a;
                    alu_b_n      = head.b;
                    alu_opcode_n = head.op;
                    res_op_n     = head.op;
                    cnt_n        = '0;
                    state_n      = WAIT;
                end
            end
            WAIT: begin
                // By the edge where cnt == ALU_LAT the ALU output register has
                // held the result for this operand set for a full cycle.
                if (cnt == CW'(ALU_LAT)) begin
                    res_s_n     = alu_s;
                    res_flag_n  = alu_flag;
                    res_valid_n = 1'b1;
                    state_n     = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef CONTROLADOR_ULA_CONTADOR_EN
    // Wraps naturally from 16'hFFFF to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (res_valid && res_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_controlador_ula.sv
// tb_controlador_ula: bench for controlador_ula with a two-stage registered
// ALU model attached (input registers, then output register).
module tb_controlador_ula;
    import ula_pkg::*;

    localparam int N  = 8;
    localparam int EW = N + 4;  // {op, flag, s}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [N-1:0] cmd_a = '0;
    logic [N-1:0] cmd_b = '0;
    logic [2:0]   cmd_op = '0;
    logic [N-1:0] alu_a, alu_b;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_s = '0;
    logic         alu_flag = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] res_s;
    logic         res_flag;
    logic [2:0]   res_op;
    logic         busy;
`ifdef CONTROLADOR_ULA_CONTADOR_EN
    logic [15:0]  op_count;
`endif

    controlador_ula #(.N(N), .DEPTH(4), .ALU_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_s      (alu_s),
        .alu_flag   (alu_flag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_flag   (res_flag),
        .res_op     (res_op),
        .busy       (busy)
`ifdef CONTROLADOR_ULA_CONTADOR_EN
        ,
        .op_count   (op_count)
`endif
    );

    // ---------------- ALU behaviour ----------------
    // Returns {flag, s}. Flag is carry for add, borrow for sub, 0 otherwise.
    function automatic logic [N:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [2:0] op);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            OP_SOMA:  begin r = ia + ib; return {r >= 256, r[N-1:0]}; end
            OP_SUB:   begin r = ia - ib + 256; return {ia < ib, r[N-1:0]}; end
            OP_AND:   return {1'b0, a & b};
            OP_OR:    return {1'b0, a | b};
            OP_XOR:   return {1'b0, a ^ b};
            OP_NOT:   return {1'b0, ~a};
            OP_IGUAL: return {1'b0, (a == b) ? 8'd1 : 8'd0};
            default:  return {1'b0, (a != b) ? 8'd1 : 8'd0};
        endcase
    endfunction

    // Two-cycle registered ALU attached to the DUT.
    logic [N-1:0] ra = '0, rb = '0;
    logic [2:0]   rop = '0;
    always @(posedge clk) begin
        ra  <= alu_a;
        rb  <= alu_b;
        rop <= alu_opcode;
        {alu_flag, alu_s} <= alu_fn(ra, rb, rop);
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_hs = -1;
    int hs_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is sampled at the falling edge and completes on
    // the next rising edge.
    logic [EW-1:0] mon_e;
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("res_without_cmd", 32'(res_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_s",    32'(res_s),    32'(mon_e[N-1:0]));
                chk("res_flag", 32'(res_flag), 32'(mon_e[N]));
                chk("res_op",   32'(res_op),   32'(mon_e[N+3:N+1]));
            end
            if (last_hs >= 0) chk("issue_gap_ge5", 32'((cyc - last_hs) >= 5), 32'd1);
            last_hs  = cyc;
            hs_count = hs_count + 1;
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        int t;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back({op, alu_fn(a, b, op)});
                break;
            end
            t++;
            if (t > 200) begin
                chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 0);
        chk({tag, "_busy"},      32'(busy), 0);
        chk({tag, "_alu_a"},     32'(alu_a), 0);
        chk({tag, "_alu_b"},     32'(alu_b), 0);
        chk({tag, "_alu_op"},    32'(alu_opcode), 0);
        chk({tag, "_res_s"},     32'(res_s), 0);
        chk({tag, "_res_flag"},  32'(res_flag), 0);
        chk({tag, "_res_op"},    32'(res_op), 0);
    endtask

    task automatic drain(input string tag);
        int t;
        res_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            tick(1);
            t++;
        end
        chk({tag, "_drain_left"}, 32'(exp_q.size()), 0);
        tick(2);
    endtask

    // ---------------- stimulus ----------------
    logic          tx_done;
    logic [N-1:0]  snap_s, snap_a, snap_b;
    logic          snap_f;
    logic [2:0]    snap_op, snap_aop;

    initial begin
        int k;
        // Reset state
        #1;
        check_zero_outputs("reset");
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_reset", 32'(cmd_ready), 1);

        // Single ADD, latency and values
        res_ready = 1'b1;
        send(8'hF0, 8'h20, OP_SOMA);
        k = 0;
        while (!res_valid && k < 20) begin
            tick(1);
            k++;
        end
        chk("add_latency", 32'(k), 4);
        chk("add_res_s", 32'(res_s), 32'h10);
        chk("add_flag", 32'(res_flag), 1);
        drain("add");

        // XOR then NOT, back to back
        send(8'hAA, 8'hFF, OP_XOR);
        send(8'h0F, 8'h00, OP_NOT);
        drain("xor_not");

        // Fill with downstream stalled
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(i * 37 + 5), 8'(i * 11 + 3), 3'(i));
        chk("full_ready_low", 32'(cmd_ready), 0);
        k = 0;
        while (!res_valid && k < 20) begin
            tick(1);
            k++;
        end
        chk("stall_res_valid", 32'(res_valid), 1);
        snap_s = res_s; snap_f = res_flag; snap_op = res_op;
        snap_a = alu_a; snap_b = alu_b; snap_aop = alu_opcode;
        // A sixth command must stall while everything holds still.
        cmd_a = 8'h99; cmd_b = 8'h66; cmd_op = OP_AND; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_cmd_ready", 32'(cmd_ready), 0);
            chk("stall_hold", {res_s, res_flag, res_op, alu_a, alu_b, alu_opcode},
                {snap_s, snap_f, snap_op, snap_a, snap_b, snap_aop});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        drain("stall");

        // Reset during WAIT with two commands queued
        send(8'h12, 8'h34, OP_SUB);
        send(8'h56, 8'h78, OP_OR);
        send(8'h9A, 8'hBC, OP_DIF);
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_zero_outputs("midreset");
        tick(2);
        rst_n = 1'b1;
        last_hs = -1;
        hs_count = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("post_reset_idle", {31'd0, busy | res_valid}, 0);
        end
        chk("post_reset_ready", 32'(cmd_ready), 1);

        // Randomized traffic with random downstream backpressure
        tx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
                    tick($urandom_range(0, 3));
                end
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    res_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
            end
        join
        drain("random");

`ifdef CONTROLADOR_ULA_CONTADOR_EN
        chk("op_count", 32'(op_count), 32'(hs_count[15:0]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
